// File: rtl/risc16_pkg.sv
// Shared types for the RiSC-16 memory subsystem: requester IDs and arbiter states.
package risc16_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        IF   = 2'd1,
        DM   = 2'd2,
        HOST = 2'd3
    } req_id_t;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Bit positions in the one-hot request/grant vectors.
    localparam int unsigned GNT_IF   = 0;
    localparam int unsigned GNT_DM   = 1;
    localparam int unsigned GNT_HOST = 2;

endpackage

// File: rtl/arb_prio3.sv
// Three-way fixed-priority picker: host first, then data/fetch in an order
// that swap_if_dm_i can flip. Output is one-hot (or zero when nothing requests).
module arb_prio3
    import risc16_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic       swap_if_dm_i,
    output logic [2:0] gnt_o
);

    always_comb begin
        gnt_o = '0;
        if (req_i[GNT_HOST]) begin
            gnt_o[GNT_HOST] = 1'b1;
        end else if (swap_if_dm_i) begin
            if (req_i[GNT_IF])      gnt_o[GNT_IF] = 1'b1;
            else if (req_i[GNT_DM]) gnt_o[GNT_DM] = 1'b1;
        end else begin
            if (req_i[GNT_DM])      gnt_o[GNT_DM] = 1'b1;
            else if (req_i[GNT_IF]) gnt_o[GNT_IF] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read memory among fetch, data and host ports with a
// fetch starvation guard and a host lock mode that freezes the core.
module mem_arbiter
    import risc16_pkg::*;
#(
    parameter int p_WORD_LEN     = 16,
    parameter int p_ADDR_LEN     = 16,
    parameter int p_STARVE_LIMIT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,

    input  logic                  i_if_req,
    input  logic [p_ADDR_LEN-1:0] i_if_addr,
    output logic                  o_if_gnt,
    output logic                  o_if_rvalid,
    output logic [p_WORD_LEN-1:0] o_if_rdata,

    input  logic                  i_dm_req,
    input  logic                  i_dm_we,
    input  logic [p_ADDR_LEN-1:0] i_dm_addr,
    input  logic [p_WORD_LEN-1:0] i_dm_wdata,
    output logic                  o_dm_gnt,
    output logic                  o_dm_rvalid,
    output logic [p_WORD_LEN-1:0] o_dm_rdata,

    input  logic                  i_host_req,
    input  logic                  i_host_we,
    input  logic [p_ADDR_LEN-1:0] i_host_addr,
    input  logic [p_WORD_LEN-1:0] i_host_wdata,
    output logic                  o_host_gnt,
    output logic                  o_host_rvalid,
    output logic [p_WORD_LEN-1:0] o_host_rdata,

    input  logic                  i_host_lock,
    output logic                  o_locked,

    output logic                  o_mem_en,
    output logic                  o_mem_we,
    output logic [p_ADDR_LEN-1:0] o_mem_addr,
    output logic [p_WORD_LEN-1:0] o_mem_wdata,
    input  logic [p_WORD_LEN-1:0] i_mem_rdata,

    output logic                  o_core_stall
);

    localparam logic [3:0] STARVE_MAX = 4'(p_STARVE_LIMIT);

    arb_state_t r_state, state_d;
    logic [3:0] r_starve, starve_d;
    req_id_t    r_rd_owner, rd_owner_d;

    logic [2:0] req_m;
    logic [2:0] gnt;
    logic       core_ok;

    // Core ports are masked while locked; everything is masked during reset.
    assign core_ok = (r_state == ARB);
    assign req_m   = i_rst ? 3'b000
                           : {i_host_req, i_dm_req & core_ok, i_if_req & core_ok};

    arb_prio3 u_prio (
        .req_i        (req_m),
        .swap_if_dm_i (r_starve == STARVE_MAX),
        .gnt_o        (gnt)
    );

    assign o_if_gnt     = gnt[GNT_IF];
    assign o_dm_gnt     = gnt[GNT_DM];
    assign o_host_gnt   = gnt[GNT_HOST];
    assign o_core_stall = (i_if_req && !o_if_gnt) || (i_dm_req && !o_dm_gnt);
    assign o_locked     = (r_state == LOCKED);

    always_comb begin
        o_mem_en    = |gnt;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (gnt[GNT_HOST]) begin
            o_mem_we    = i_host_we;
            o_mem_addr  = i_host_addr;
            o_mem_wdata = i_host_wdata;
        end else if (gnt[GNT_DM]) begin
            o_mem_we    = i_dm_we;
            o_mem_addr  = i_dm_addr;
            o_mem_wdata = i_dm_wdata;
        end else if (gnt[GNT_IF]) begin
            o_mem_addr  = i_if_addr;
        end
    end

    // Read return steers the memory's registered output to last cycle's reader;
    // gated by reset so an in-flight read is dropped immediately.
    assign o_if_rvalid   = !i_rst && (r_rd_owner == IF);
    assign o_dm_rvalid   = !i_rst && (r_rd_owner == DM);
    assign o_host_rvalid = !i_rst && (r_rd_owner == HOST);
    assign o_if_rdata    = o_if_rvalid   ? i_mem_rdata : '0;
    assign o_dm_rdata    = o_dm_rvalid   ? i_mem_rdata : '0;
    assign o_host_rdata  = o_host_rvalid ? i_mem_rdata : '0;

    always_comb begin
        rd_owner_d = NONE;
        if (gnt[GNT_HOST] && !i_host_we)  rd_owner_d = HOST;
        else if (gnt[GNT_DM] && !i_dm_we) rd_owner_d = DM;
        else if (gnt[GNT_IF])             rd_owner_d = IF;
    end

    always_comb begin
        starve_d = r_starve;
        if (r_state == LOCKED || !i_if_req || gnt[GNT_IF]) begin
            starve_d = 4'd0;
        end else if (r_starve < STARVE_MAX) begin
            starve_d = r_starve + 4'd1;
        end
    end

    assign state_d = i_host_lock ? LOCKED : ARB;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ARB;
            r_starve   <= 4'd0;
            r_rd_owner <= NONE;
        end else begin
            r_state    <= state_d;
            r_starve   <= starve_d;
            r_rd_owner <= rd_owner_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: per-cycle grant/stall/lock checks plus
// expected read data queued at grant time and compared when rvalid appears.
module tb_mem_arbiter;

    localparam logic [2:0] G_NO = 3'b000, G_IF = 3'b001, G_DM = 3'b010, G_HOST = 3'b100;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_if_req = 0, i_dm_req = 0, i_dm_we = 0, i_host_req = 0, i_host_we = 0, i_host_lock = 0;
    logic [15:0] i_if_addr = 0, i_dm_addr = 0, i_dm_wdata = 0, i_host_addr = 0, i_host_wdata = 0;
    logic        o_if_gnt, o_if_rvalid, o_dm_gnt, o_dm_rvalid, o_host_gnt, o_host_rvalid;
    logic [15:0] o_if_rdata, o_dm_rdata, o_host_rdata;
    logic        o_locked, o_mem_en, o_mem_we, o_core_stall;
    logic [15:0] o_mem_addr, o_mem_wdata;
    logic [15:0] i_mem_rdata = 16'h0;

    always #5 i_clk = ~i_clk;

    mem_arbiter #(.p_WORD_LEN(16), .p_ADDR_LEN(16), .p_STARVE_LIMIT(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
        .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
        .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_addr(i_dm_addr), .i_dm_wdata(i_dm_wdata),
        .o_dm_gnt(o_dm_gnt), .o_dm_rvalid(o_dm_rvalid), .o_dm_rdata(o_dm_rdata),
        .i_host_req(i_host_req), .i_host_we(i_host_we), .i_host_addr(i_host_addr),
        .i_host_wdata(i_host_wdata), .o_host_gnt(o_host_gnt), .o_host_rvalid(o_host_rvalid),
        .o_host_rdata(o_host_rdata), .i_host_lock(i_host_lock), .o_locked(o_locked),
        .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .o_core_stall(o_core_stall)
    );

    // Memory macro: synchronous read, read-before-write.
    logic [15:0] tb_mem  [0:1023];
    logic [15:0] ref_mem [0:1023];
    always @(posedge i_clk) begin
        if (o_mem_en) begin
            if (o_mem_we) tb_mem[o_mem_addr[9:0]] <= o_mem_wdata;
            i_mem_rdata <= tb_mem[o_mem_addr[9:0]];
        end
    end

    typedef struct { int port; logic [15:0] data; int cyc; } sb_t;
    sb_t sb_q[$];
    int  n_chk = 0, n_pass = 0, cyc_n = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc_n, got, exp);
    endtask

    task automatic drive(input logic ifr, input logic [15:0] ifa,
                         input logic dmr, input logic dmw, input logic [15:0] dma, input logic [15:0] dmd,
                         input logic hr, input logic hw, input logic [15:0] ha, input logic [15:0] hd,
                         input logic lk);
        @(negedge i_clk);
        i_rst = 0;
        i_if_req = ifr;   i_if_addr = ifa;
        i_dm_req = dmr;   i_dm_we = dmw;   i_dm_addr = dma;   i_dm_wdata = dmd;
        i_host_req = hr;  i_host_we = hw;  i_host_addr = ha;  i_host_wdata = hd;
        i_host_lock = lk;
    endtask

    task automatic expect_cyc(input logic [2:0] eg, input logic est, input logic elk);
        logic [2:0]  ev;
        logic [15:0] ed, ea, ewd;
        logic        ew;
        int          ep;
        sb_t         e;
        #1;
        check("gnt", {29'd0, o_host_gnt, o_dm_gnt, o_if_gnt}, {29'd0, eg});
        check("stall", {31'd0, o_core_stall}, {31'd0, est});
        check("locked", {31'd0, o_locked}, {31'd0, elk});
        ev = 3'b000; ed = 16'h0;
        if (sb_q.size() > 0 && sb_q[0].cyc == cyc_n - 1) begin
            e = sb_q.pop_front();
            ev[e.port] = 1'b1;
            ed = e.data;
        end
        check("rvalid", {29'd0, o_host_rvalid, o_dm_rvalid, o_if_rvalid}, {29'd0, ev});
        check("if_rdata", {16'd0, o_if_rdata}, {16'd0, ev[0] ? ed : 16'h0});
        check("dm_rdata", {16'd0, o_dm_rdata}, {16'd0, ev[1] ? ed : 16'h0});
        check("host_rdata", {16'd0, o_host_rdata}, {16'd0, ev[2] ? ed : 16'h0});
        if (eg == G_NO) begin
            check("mem_en_idle", {31'd0, o_mem_en}, 32'd0);
            check("mem_addr_idle", {16'd0, o_mem_addr}, 32'd0);
        end else begin
            if (eg == G_HOST)    begin ep = 2; ea = i_host_addr; ew = i_host_we; ewd = i_host_wdata; end
            else if (eg == G_DM) begin ep = 1; ea = i_dm_addr;   ew = i_dm_we;   ewd = i_dm_wdata;   end
            else                 begin ep = 0; ea = i_if_addr;   ew = 1'b0;      ewd = 16'h0;        end
            check("mem_en", {31'd0, o_mem_en}, 32'd1);
            check("mem_addr", {16'd0, o_mem_addr}, {16'd0, ea});
            check("mem_we", {31'd0, o_mem_we}, {31'd0, ew});
            if (ew) begin
                check("mem_wdata", {16'd0, o_mem_wdata}, {16'd0, ewd});
                ref_mem[ea[9:0]] = ewd;
            end else begin
                sb_q.push_back('{port: ep, data: ref_mem[ea[9:0]], cyc: cyc_n});
            end
        end
        cyc_n++;
    endtask

    task automatic rst_cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge i_clk);
            i_rst = 1;
            i_if_req = 1; i_if_addr = 16'h0001;
            i_dm_req = 0; i_host_req = 0; i_host_lock = 0;
            #1;
            check("rst_gnt", {29'd0, o_host_gnt, o_dm_gnt, o_if_gnt}, 32'd0);
            check("rst_mem_en", {31'd0, o_mem_en}, 32'd0);
            check("rst_rvalid", {29'd0, o_host_rvalid, o_dm_rvalid, o_if_rvalid}, 32'd0);
            check("rst_if_rdata", {16'd0, o_if_rdata}, 32'd0);
            check("rst_dm_rdata", {16'd0, o_dm_rdata}, 32'd0);
            check("rst_host_rdata", {16'd0, o_host_rdata}, 32'd0);
            check("rst_stall", {31'd0, o_core_stall}, 32'd1);
            if (k > 0) check("rst_locked", {31'd0, o_locked}, 32'd0);
            sb_q.delete();
            cyc_n++;
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_cyc(G_NO, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            tb_mem[i]  = 16'h1000 + 16'(i);
            ref_mem[i] = 16'h1000 + 16'(i);
        end
        rst_cyc(2);

        // Fetch-only stream, one grant per cycle.
        for (int a = 0; a < 4; a++) begin
            drive(1, 16'(a), 0, 0, 0, 0, 0, 0, 0, 0, 0);
            expect_cyc(G_IF, 0, 0);
        end
        idle();

        // Fetch vs data: the starvation guard lets fetch through on the 5th cycle.
        for (int k = 0; k < 6; k++) begin
            drive(1, (k <= 4) ? 16'd4 : 16'd5, 1, 0, 16'd8, 0, 0, 0, 0, 0, 0);
            expect_cyc((k == 4) ? G_IF : G_DM, 1, 0);
        end
        idle();

        // Host write outranks a data read of the same address.
        drive(0, 0, 1, 0, 16'h0040, 0, 1, 1, 16'h0040, 16'hBEEF, 0);
        expect_cyc(G_HOST, 1, 0);
        drive(0, 0, 1, 0, 16'h0040, 0, 0, 0, 0, 0, 0);
        expect_cyc(G_DM, 0, 0);
        idle();

        // Lock for 5 cycles with fetch pending; host reads while locked.
        for (int k = 0; k < 7; k++) begin
            drive(1, (k == 0) ? 16'd6 : 16'd7, 0, 0, 0, 0,
                  k == 2, 0, (k == 2) ? 16'h0040 : 16'h0, 0, k < 5);
            expect_cyc((k == 0) ? G_IF : (k == 2) ? G_HOST : (k == 6) ? G_IF : G_NO,
                       !(k == 0 || k == 6), k >= 1 && k <= 5);
        end
        // Starve count restarted from zero after the lock.
        for (int j = 0; j < 5; j++) begin
            drive(1, 16'd8, 1, 0, 16'd9, 0, 0, 0, 0, 0, 0);
            expect_cyc((j == 4) ? G_IF : G_DM, 1, 0);
        end
        idle();

        // Data write then readback.
        drive(0, 0, 1, 1, 16'h0050, 16'h1234, 0, 0, 0, 0, 0);
        expect_cyc(G_DM, 0, 0);
        drive(0, 0, 1, 0, 16'h0050, 0, 0, 0, 0, 0, 0);
        expect_cyc(G_DM, 0, 0);
        idle();

        // Reset right after a fetch read grant (with lock raised) drops the read.
        drive(1, 16'd2, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        expect_cyc(G_IF, 0, 0);
        rst_cyc(1);
        idle();
        drive(1, 16'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_cyc(G_IF, 0, 0);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
